reg_access_seq: RTL

REG_ACCESS_SEQ -- requirements
Module: reg_access_seq

---
 rtl/reg_access_seq_pkg.sv | 28 ++
 rtl/reg_access_seq.sv | 123 ++++++++++++
 2 files changed

// File: rtl/reg_access_seq_pkg.sv
// Shared constants and state encoding for the register-file access sequencer.
// R0_ZERO_EN: when defined, register 0 reads as zero and is never written.
package reg_access_seq_pkg;

  localparam int REG_AW  = 5;
  localparam int REG_DW  = 32;
  localparam int REG_NUM = 32;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD1  = 3'd1,
    S_RD2  = 3'd2,
    S_WR   = 3'd3,
    S_RSP  = 3'd4
  } state_e;

`ifdef R0_ZERO_EN
  localparam bit R0_ZERO = 1'b1;
`else
  localparam bit R0_ZERO = 1'b0;
`endif

  // True when the register behaves as a hard-wired zero in this build.
  function automatic logic is_zero_reg(input logic [REG_AW-1:0] addr);
    return R0_ZERO && (addr == '0);
  endfunction

endpackage

// File: rtl/reg_access_seq.sv
// Sequences two operand reads and an optional writeback over a single-port register file.
// Build option R0_ZERO_EN (see package) makes register 0 read as zero and ignore writes.
module reg_access_seq
  import reg_access_seq_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [REG_AW-1:0] rs1_addr,
  input  logic [REG_AW-1:0] rs2_addr,
  input  logic [REG_AW-1:0] rd_addr,
  input  logic              rd_we,
  input  logic [REG_DW-1:0] rd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [REG_DW-1:0] op1,
  output logic [REG_DW-1:0] op2,
  output logic              reg_write,
  output logic [REG_AW-1:0] reg_adress,
  output logic [REG_DW-1:0] data_write,
  input  logic [REG_DW-1:0] data_read,
  output state_e            dbg_state
);

  // Handshake: a transfer happens on a rising edge where valid and ready are both 1;
  // valid holds its payload until that edge, ready may change freely.
  state_e            state_q, state_d;
  logic [REG_AW-1:0] rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
  logic              rd_we_q, rd_we_d;
  logic [REG_DW-1:0] wdata_q, wdata_d;
  logic [REG_DW-1:0] op1_q, op1_d, op2_q, op2_d;
  logic              reg_write_q, reg_write_d;
  logic [REG_AW-1:0] adr_q, adr_d;
  logic [REG_DW-1:0] dwr_q, dwr_d;

  always_comb begin
    state_d     = state_q;
    rs1_d       = rs1_q;
    rs2_d       = rs2_q;
    rd_d        = rd_q;
    rd_we_d     = rd_we_q;
    wdata_d     = wdata_q;
    op1_d       = op1_q;
    op2_d       = op2_q;
    reg_write_d = 1'b0;
    adr_d       = adr_q;
    dwr_d       = dwr_q;
    // The register file reads with one cycle of latency, so the address for
    // each phase is loaded on the edge that enters that phase.
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          rs1_d   = rs1_addr;
          rs2_d   = rs2_addr;
          rd_d    = rd_addr;
          rd_we_d = rd_we;
          wdata_d = rd_wdata;
          adr_d   = rs1_addr;
          state_d = S_RD1;
        end
      end
      S_RD1: begin
        adr_d   = rs2_q;
        state_d = S_RD2;
      end
      S_RD2: begin
        op1_d       = is_zero_reg(rs1_q) ? '0 : data_read;
        adr_d       = rd_q;
        dwr_d       = wdata_q;
        reg_write_d = rd_we_q && !is_zero_reg(rd_q);
        state_d     = S_WR;
      end
      S_WR: begin
        // rs2 data was fetched in RD2, so it is the pre-write value.
        op2_d   = is_zero_reg(rs2_q) ? '0 : data_read;
        state_d = S_RSP;
      end
      S_RSP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      rs1_q       <= '0;
      rs2_q       <= '0;
      rd_q        <= '0;
      rd_we_q     <= 1'b0;
      wdata_q     <= '0;
      op1_q       <= '0;
      op2_q       <= '0;
      reg_write_q <= 1'b0;
      adr_q       <= '0;
      dwr_q       <= '0;
    end else begin
      state_q     <= state_d;
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
      rd_q        <= rd_d;
      rd_we_q     <= rd_we_d;
      wdata_q     <= wdata_d;
      op1_q       <= op1_d;
      op2_q       <= op2_d;
      reg_write_q <= reg_write_d;
      adr_q       <= adr_d;
      dwr_q       <= dwr_d;
    end
  end

  assign req_ready  = (state_q == S_IDLE);
  assign rsp_valid  = (state_q == S_RSP);
  assign op1        = op1_q;
  assign op2        = op2_q;
  assign reg_write  = reg_write_q;
  assign reg_adress = adr_q;
  assign data_write = dwr_q;
  assign dbg_state  = state_q;

endmodule
